// File: rtl/systolic_pkg.sv
// Shared systolic-array types: element/row widths, block dimension and bank ids.
// Used by transpose_buffer (optional bypass via TRANSPOSE_BYPASS_EN) and transpose_bank.
package systolic_pkg;

  localparam int unsigned ELEM_W = 16;
  localparam int unsigned DIM    = 4;
  localparam int unsigned DATA_W = ELEM_W * DIM;
  localparam int unsigned CNT_W  = $clog2(DIM);

  typedef logic [ELEM_W-1:0] elem_t;
  typedef elem_t [DIM-1:0]   row_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_e;

  localparam cnt_t CNT_LAST = cnt_t'(DIM - 1);

endpackage

// File: rtl/transpose_bank.sv
// One DIM x DIM element register array: row-wide write port, column-wide combinational read.
// Contents are intentionally not reset.
module transpose_bank
  import systolic_pkg::*;
(
  input  logic clk,
  input  logic wr_en,
  input  cnt_t wr_row,
  input  row_t wr_data,
  input  cnt_t rd_col,
  output row_t rd_data
);

  row_t mem [DIM];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < DIM; k++) begin
      rd_data[k] = mem[k][rd_col];
    end
  end

endmodule

// File: rtl/transpose_buffer.sv
// Ping-pong DIM x DIM transposer: rows written into one bank, columns read from the other.
// Define TRANSPOSE_BYPASS_EN to add the bypass port (untransposed 1-cycle pass-through).
module transpose_buffer
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rst_sync,
  input  logic              sel,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_row,
`ifdef TRANSPOSE_BYPASS_EN
  input  logic              bypass,
`endif
  output logic [DATA_W-1:0] out_col,
  output logic              out_valid,
  output logic              sync_err
);

  cnt_t        wr_cnt, wr_cnt_d;
  cnt_t        rd_cnt, rd_cnt_d;
  logic [1:0]  bank_full, bank_full_d;
  logic [DATA_W-1:0] out_col_d;
  logic        out_valid_d;
  logic        sync_err_d;
  logic        sel_q;

  logic        swap;
  logic        bypass_on;
  logic        bank_we;
  bank_e       wr_bank, rd_bank;
  cnt_t        wr_idx, rd_idx;
  row_t        rd_data_a, rd_data_b, rd_data;

`ifdef TRANSPOSE_BYPASS_EN
  assign bypass_on = bypass;
`else
  assign bypass_on = 1'b0;
`endif

  assign wr_bank = sel ? BANK_A : BANK_B;
  assign rd_bank = sel ? BANK_B : BANK_A;
  assign swap    = (sel != sel_q);
  // A swap restarts both pointers, so the swap cycle itself writes row 0 and reads column 0.
  assign wr_idx  = swap ? '0 : wr_cnt;
  assign rd_idx  = swap ? '0 : rd_cnt;
  assign rd_data = (rd_bank == BANK_B) ? rd_data_b : rd_data_a;

  transpose_bank u_bank_a (
    .clk     (clk),
    .wr_en   (bank_we && (wr_bank == BANK_A)),
    .wr_row  (wr_idx),
    .wr_data (row_t'(in_row)),
    .rd_col  (rd_idx),
    .rd_data (rd_data_a)
  );

  transpose_bank u_bank_b (
    .clk     (clk),
    .wr_en   (bank_we && (wr_bank == BANK_B)),
    .wr_row  (wr_idx),
    .wr_data (row_t'(in_row)),
    .rd_col  (rd_idx),
    .rd_data (rd_data_b)
  );

  always_comb begin
    wr_cnt_d    = wr_cnt;
    rd_cnt_d    = rd_cnt;
    bank_full_d = bank_full;
    out_col_d   = out_col;
    out_valid_d = 1'b0;
    sync_err_d  = sync_err;
    bank_we     = 1'b0;

    if (rst_sync) begin
      wr_cnt_d    = '0;
      rd_cnt_d    = '0;
      bank_full_d = '0;
      out_col_d   = '0;
      sync_err_d  = 1'b0;
    end else if (bypass_on) begin
      out_col_d   = in_row;
      out_valid_d = in_valid;
    end else begin
      if (swap) begin
        if (wr_cnt != '0) begin
          sync_err_d = 1'b1;
        end
        wr_cnt_d = '0;
        rd_cnt_d = '0;
      end

      if (in_valid) begin
        bank_we  = 1'b1;
        wr_cnt_d = wr_idx + 1'b1;
        if (bank_full[wr_bank]) begin
          sync_err_d = 1'b1;
        end
        if (wr_idx == CNT_LAST) begin
          bank_full_d[wr_bank] = 1'b1;
        end
      end

      if (bank_full[rd_bank]) begin
        out_col_d   = rd_data;
        out_valid_d = 1'b1;
        rd_cnt_d    = rd_idx + 1'b1;
        if (rd_idx == CNT_LAST) begin
          bank_full_d[rd_bank] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      bank_full <= '0;
      out_col   <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      sel_q     <= 1'b1;
    end else begin
      wr_cnt    <= wr_cnt_d;
      rd_cnt    <= rd_cnt_d;
      bank_full <= bank_full_d;
      out_col   <= out_col_d;
      out_valid <= out_valid_d;
      sync_err  <= sync_err_d;
      sel_q     <= sel;
    end
  end

endmodule

// File: tb/tb_transpose_buffer.sv
// Scoreboard bench for transpose_buffer: stimulus pushes expected columns, a monitor pops them.
module tb_transpose_buffer;
  import systolic_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rst_sync;
  logic              sel;
  logic              in_valid;
  logic [DATA_W-1:0] in_row;
  logic [DATA_W-1:0] out_col;
  logic              out_valid;
  logic              sync_err;
`ifdef TRANSPOSE_BYPASS_EN
  logic              bypass;
`endif

  int total = 0;
  int bad   = 0;
  int gaps;
  logic [DATA_W-1:0] exp_q [$];
  row_t blk [DIM];

  always #5 clk = ~clk;

  transpose_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rst_sync  (rst_sync),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_row    (in_row),
`ifdef TRANSPOSE_BYPASS_EN
    .bypass    (bypass),
`endif
    .out_col   (out_col),
    .out_valid (out_valid),
    .sync_err  (sync_err)
  );

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented column must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_col: got %h expected none", out_col);
      end else begin
        check("out_col", out_col, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_transpose();
    row_t col;
    for (int c = 0; c < DIM; c++) begin
      for (int k = 0; k < DIM; k++) col[k] = blk[k][c];
      exp_q.push_back(col);
    end
  endtask

  task automatic write_block(input logic s, input int base, input bit count_gaps);
    for (int r = 0; r < DIM; r++) begin
      for (int j = 0; j < DIM; j++) blk[r][j] = elem_t'(base + r * DIM + j);
      sel      = s;
      in_valid = 1'b1;
      in_row   = blk[r];
      step();
      if (count_gaps && !out_valid) gaps++;
    end
    in_valid = 1'b0;
    push_transpose();
  endtask

  task automatic drain(input logic s, input int n);
    sel      = s;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n    = 1'b0;
    rst_sync = 1'b0;
    sel      = 1'b1;
    in_valid = 1'b0;
    in_row   = '0;
`ifdef TRANSPOSE_BYPASS_EN
    bypass   = 1'b0;
`endif
    #2;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_col", out_col, 64'd0);
    check("reset_sync_err", {63'd0, sync_err}, 64'd0);
    #10 rst_n = 1'b1;

    // 1: basic transpose with hand-computed columns
    rst_sync = 1'b1;
    step();
    rst_sync = 1'b0;
    in_valid = 1'b1;
    in_row = 64'h0003_0002_0001_0000; step();
    in_row = 64'h0007_0006_0005_0004; step();
    in_row = 64'h000B_000A_0009_0008; step();
    in_row = 64'h000F_000E_000D_000C; step();
    exp_q.push_back(64'h000C_0008_0004_0000);
    exp_q.push_back(64'h000D_0009_0005_0001);
    exp_q.push_back(64'h000E_000A_0006_0002);
    exp_q.push_back(64'h000F_000B_0007_0003);
    drain(1'b0, 6);
    check("t1_sync_err", {63'd0, sync_err}, 64'd0);
    check("t1_queue_left", 64'(exp_q.size()), 64'd0);

    // 2: continuous ping-pong, 8 blocks, no gaps once streaming
    rst_sync = 1'b1;
    sel = 1'b1;
    step();
    rst_sync = 1'b0;
    gaps = 0;
    for (int b = 0; b < 8; b++) write_block((b % 2) == 0, 'h100 + b * 16, b > 0);
    sel = 1'b1;
    for (int i = 0; i < DIM; i++) begin
      step();
      if (!out_valid) gaps++;
    end
    check("t2_gaps", 64'(gaps), 64'd0);
    step();
    check("t2_idle_valid", {63'd0, out_valid}, 64'd0);
    check("t2_sync_err", {63'd0, sync_err}, 64'd0);
    check("t2_queue_left", 64'(exp_q.size()), 64'd0);

    // 3: early swap discards the partial bank
    sel = 1'b1;
    in_valid = 1'b1;
    in_row = 64'hAAAA_AAAA_AAAA_AAAA; step();
    in_row = 64'hBBBB_BBBB_BBBB_BBBB; step();
    sel = 1'b0;
    in_valid = 1'b0;
    step();
    check("t3_sync_err_set", {63'd0, sync_err}, 64'd1);
    step();
    check("t3_no_partial_out", {63'd0, out_valid}, 64'd0);
    write_block(1'b0, 'h300, 1'b0);
    drain(1'b1, 6);
    check("t3_sync_err_sticky", {63'd0, sync_err}, 64'd1);
    check("t3_queue_left", 64'(exp_q.size()), 64'd0);

    // 4: rst_sync after two columns
    write_block(1'b1, 'h400, 1'b0);
    drain(1'b0, 2);
    rst_sync = 1'b1;
    @(negedge clk);
    #1 exp_q.delete();
    step();
    rst_sync = 1'b0;
    check("t4_out_valid", {63'd0, out_valid}, 64'd0);
    check("t4_out_col", out_col, 64'd0);
    check("t4_sync_err", {63'd0, sync_err}, 64'd0);
    write_block(1'b0, 'h500, 1'b0);
    drain(1'b1, 6);
    check("t4_queue_left", 64'(exp_q.size()), 64'd0);

    // 5: async reset mid-write while streaming
    sel = 1'b1;
    in_valid = 1'b1;
    in_row = 64'hCCCC_CCCC_CCCC_CCCC;
    step();
    write_block(1'b0, 'h600, 1'b0);
    sel = 1'b1;
    in_valid = 1'b1;
    in_row = 64'hDDDD_DDDD_DDDD_DDDD;
    step();
    step();
    check("t5_pre_valid", {63'd0, out_valid}, 64'd1);
    check("t5_pre_sync_err", {63'd0, sync_err}, 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_rst_valid", {63'd0, out_valid}, 64'd0);
    check("t5_rst_sync_err", {63'd0, sync_err}, 64'd0);
    check("t5_rst_out_col", out_col, 64'd0);
    in_valid = 1'b0;
    step();
    step();
    #2 rst_n = 1'b1;
    write_block(1'b1, 'h700, 1'b0);
    drain(1'b0, 6);
    check("t5_sync_err", {63'd0, sync_err}, 64'd0);
    check("t5_queue_left", 64'(exp_q.size()), 64'd0);

`ifdef TRANSPOSE_BYPASS_EN
    // 6: bypass passes a row through and leaves bank state untouched
    write_block(1'b1, 'h800, 1'b0);
    exp_q.push_front(64'h1234_5678_9ABC_DEF0);
    bypass   = 1'b1;
    in_valid = 1'b1;
    in_row   = 64'h1234_5678_9ABC_DEF0;
    step();
    check("t6_bypass_col", out_col, 64'h1234_5678_9ABC_DEF0);
    check("t6_bypass_valid", {63'd0, out_valid}, 64'd1);
    bypass = 1'b0;
    drain(1'b0, 6);
    check("t6_queue_left", 64'(exp_q.size()), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
